// File: rtl/ram_fill_arbiter.sv
`default_nettype none
// ======================================================================
// Module  : ram_fill_arbiter
// Drives one registered memory port from a fill engine, a priority CPU
// port and NCH round-robin loaders. RAM_FILL_ARB_COUNT_EN adds ld_wr_total.
// Revision: 1.0
// ======================================================================
module ram_fill_arbiter #(
    parameter int AW             = 16,
    parameter int DW             = 8,
    parameter int NCH            = 2,
    parameter     FILL_VAL       = 8'h01,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done,
    input  logic              cpu_cs,
    input  logic              cpu_we,
    input  logic [AW-1:0]     cpu_ad,
    input  logic [DW-1:0]     cpu_d,
    input  logic [NCH-1:0]    ld_valid,
    output logic [NCH-1:0]    ld_ready,
    input  logic [NCH*AW-1:0] ld_addr,
    input  logic [NCH*DW-1:0] ld_data,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [AW-1:0]     mem_a,
    output logic [DW-1:0]     mem_di,
    output logic [31:0]       ld_wr_total
);

    localparam int            PW     = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [DW-1:0] FILL_W = DW'(FILL_VAL);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t          state_q;
    logic [AW-1:0]   fill_cnt_q;
    logic [PW-1:0]   rr_q;
    logic            mem_ce_q;
    logic            mem_we_q;
    logic [AW-1:0]   mem_a_q;
    logic [DW-1:0]   mem_di_q;
    logic            clr_busy_q;
    logic            clr_done_q;

    logic [NCH-1:0]  w_rot;
    logic            w_gnt_any;
    logic [PW-1:0]   w_gnt_idx;
    logic [PW-1:0]   w_rr_nxt;
    logic [NCH-1:0]  w_grant;
    logic [AW-1:0]   w_ld_a;
    logic [DW-1:0]   w_ld_d;
    logic            w_ld_slot;
    int              w_off;
    int              w_idx;

    // Rotate the request vector so that bit 0 is the channel at the RR pointer.
    assign w_rot = NCH'({ld_valid, ld_valid} >> rr_q);

    always_comb begin
        w_off     = 0;
        w_idx     = 0;
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        w_rr_nxt  = '0;
        w_grant   = '0;
        w_ld_a    = '0;
        w_ld_d    = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_gnt_any = 1'b1;
                w_off     = k;
            end
        end
        w_idx = int'(rr_q) + w_off;
        if (w_idx >= NCH) begin
            w_idx = w_idx - NCH;
        end
        w_gnt_idx = PW'(w_idx);
        w_idx     = w_idx + 1;
        if (w_idx >= NCH) begin
            w_idx = 0;
        end
        w_rr_nxt = PW'(w_idx);
        for (int k = 0; k < NCH; k++) begin
            if (w_gnt_idx == PW'(k)) begin
                w_grant[k] = w_gnt_any;
                w_ld_a     = ld_addr[k*AW +: AW];
                w_ld_d     = ld_data[k*DW +: DW];
            end
        end
    end

    // Loaders only see a slot when neither a clear nor the CPU claims this cycle.
    assign w_ld_slot = reset_n && (state_q == ST_RUN) && !clr_start && !cpu_cs;
    assign ld_ready  = w_ld_slot ? w_grant : '0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_INIT;
            fill_cnt_q <= '0;
            rr_q       <= '0;
            mem_ce_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_a_q    <= '0;
            mem_di_q   <= '0;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b0;
        end else begin
            mem_ce_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            clr_done_q <= 1'b0;
            unique case (state_q)
                ST_INIT: begin
                    if (CLEAR_ON_RESET) begin
                        state_q    <= ST_FILL;
                        fill_cnt_q <= '0;
                        clr_busy_q <= 1'b1;
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                ST_FILL: begin
                    mem_ce_q   <= 1'b1;
                    mem_we_q   <= 1'b1;
                    mem_a_q    <= fill_cnt_q;
                    mem_di_q   <= FILL_W;
                    fill_cnt_q <= fill_cnt_q + 1'b1;
                    if (fill_cnt_q == '1) begin
                        state_q    <= ST_RUN;
                        clr_busy_q <= 1'b0;
                        clr_done_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (clr_start) begin
                        state_q    <= ST_FILL;
                        fill_cnt_q <= '0;
                        clr_busy_q <= 1'b1;
                    end else if (cpu_cs) begin
                        mem_ce_q <= 1'b1;
                        mem_we_q <= cpu_we;
                        mem_a_q  <= cpu_ad;
                        mem_di_q <= cpu_d;
                    end else if (w_gnt_any) begin
                        mem_ce_q <= 1'b1;
                        mem_we_q <= 1'b1;
                        mem_a_q  <= w_ld_a;
                        mem_di_q <= w_ld_d;
                        rr_q     <= w_rr_nxt;
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                end
            endcase
        end
    end

    assign mem_ce   = mem_ce_q;
    assign mem_we   = mem_we_q;
    assign mem_a    = mem_a_q;
    assign mem_di   = mem_di_q;
    assign clr_busy = clr_busy_q;
    assign clr_done = clr_done_q;

`ifdef RAM_FILL_ARB_COUNT_EN
    logic        w_fill_entry;
    logic        w_ld_xfer;
    logic [31:0] wr_total_q;

    assign w_fill_entry = ((state_q == ST_INIT) && CLEAR_ON_RESET)
                        || ((state_q == ST_RUN) && clr_start);
    assign w_ld_xfer    = w_ld_slot && w_gnt_any;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_total_q <= '0;
        end else if (w_fill_entry) begin
            wr_total_q <= '0;
        end else if (w_ld_xfer && (wr_total_q != 32'hFFFF_FFFF)) begin
            wr_total_q <= wr_total_q + 32'd1;
        end
    end

    assign ld_wr_total = wr_total_q;
`else
    assign ld_wr_total = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_fill_arbiter.sv
`default_nettype none
// ======================================================================
// Module  : tb_ram_fill_arbiter
// Self-checking bench: directed scenarios plus random traffic against a
// transaction-level reference model. Revision: 1.0
// ======================================================================
`timescale 1ns/1ps
module tb_ram_fill_arbiter;

    localparam int            AW = 4;
    localparam int            DW = 8;
    localparam int            NCH = 2;
    localparam logic [DW-1:0] FV = 8'h01;
`ifdef RAM_FILL_ARB_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              clr_start = 1'b0;
    logic              cpu_cs = 1'b0;
    logic              cpu_we = 1'b0;
    logic [AW-1:0]     cpu_ad = '0;
    logic [DW-1:0]     cpu_d = '0;
    logic [NCH-1:0]    ld_valid = '0;
    logic [NCH*AW-1:0] ld_addr = '0;
    logic [NCH*DW-1:0] ld_data = '0;
    logic [NCH-1:0]    ld_ready;
    logic              clr_busy, clr_done, mem_ce, mem_we;
    logic [AW-1:0]     mem_a;
    logic [DW-1:0]     mem_di;
    logic [31:0]       ld_wr_total;

    int n_checks = 0;
    int n_errors = 0;

    ram_fill_arbiter #(
        .AW(AW), .DW(DW), .NCH(NCH), .FILL_VAL(8'h01), .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
        .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_ad(cpu_ad), .cpu_d(cpu_d),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_a(mem_a), .mem_di(mem_di),
        .ld_wr_total(ld_wr_total)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: mode 0=init, 1=sweeping, 2=serving requests.
    int      m_mode = 0;
    int      m_fill = 0;
    int      m_rr = 0;
    longint  m_total = 0;
    logic          e_ce = 1'b0, e_we = 1'b0, e_busy = 1'b0, e_done = 1'b0;
    logic [AW-1:0] e_a = '0;
    logic [DW-1:0] e_di = '0;

    function automatic int pick();
        for (int k = 0; k < NCH; k++) begin
            if (ld_valid[(m_rr + k) % NCH]) return (m_rr + k) % NCH;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        int g;
        logic [NCH-1:0] er;
        chk("mem_ce", mem_ce, e_ce);
        chk("mem_we", mem_we, e_we);
        chk("mem_a", mem_a, e_a);
        chk("mem_di", mem_di, e_di);
        chk("clr_busy", clr_busy, e_busy);
        chk("clr_done", clr_done, e_done);
        chk("ld_wr_total", ld_wr_total, CNT_EN ? 64'(m_total) : 64'd0);
        g  = pick();
        er = '0;
        if (reset_n && m_mode == 2 && !clr_start && !cpu_cs && g >= 0) er[g] = 1'b1;
        chk("ld_ready", ld_ready, er);
        if (!reset_n) begin
            m_mode = 0; m_fill = 0; m_rr = 0; m_total = 0;
            e_ce = 0; e_we = 0; e_a = '0; e_di = '0; e_busy = 0; e_done = 0;
        end else begin
            e_ce = 0; e_we = 0; e_done = 0;
            case (m_mode)
                0: begin
                    m_mode = 1; m_fill = 0; e_busy = 1; m_total = 0;
                end
                1: begin
                    e_ce = 1; e_we = 1; e_a = AW'(m_fill); e_di = FV;
                    m_fill++;
                    if (m_fill == 2**AW) begin
                        m_mode = 2; e_busy = 0; e_done = 1;
                    end
                end
                default: begin
                    if (clr_start) begin
                        m_mode = 1; m_fill = 0; e_busy = 1; m_total = 0;
                    end else if (cpu_cs) begin
                        e_ce = 1; e_we = cpu_we; e_a = cpu_ad; e_di = cpu_d;
                    end else if (g >= 0) begin
                        e_ce = 1; e_we = 1;
                        e_a  = ld_addr[g*AW +: AW];
                        e_di = ld_data[g*DW +: DW];
                        m_rr = (g + 1) % NCH;
                        if (m_total < 64'hFFFF_FFFF) m_total++;
                    end
                end
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called right after reset_n rises: one INIT cycle, then a full sweep.
    task automatic sweep(input string tag);
        int nw = 0;
        int nd = 0;
        tick();
        chk({tag, "_init_ce"}, mem_ce, 1'b0);
        chk({tag, "_init_busy"}, clr_busy, 1'b1);
        for (int c = 0; c < 20; c++) begin
            tick();
            if (mem_ce) begin
                chk({tag, "_addr"}, mem_a, nw);
                chk({tag, "_data"}, mem_di, 8'h01);
                nw++;
            end
            if (clr_done) begin
                nd++;
                chk({tag, "_done_addr"}, mem_a, 4'hF);
                chk({tag, "_done_busy"}, clr_busy, 1'b0);
            end
        end
        chk({tag, "_writes"}, nw, 16);
        chk({tag, "_done_pulses"}, nd, 1);
    endtask

    initial begin
        int found;
        logic [NCH-1:0] acc;

        // Reset and power-on sweep
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        sweep("por");

        // Round-robin between two always-valid loaders
        ld_addr  = {4'hC, 4'h3};
        ld_data  = {8'hC1, 8'h30};
        ld_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_grant", ld_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            chk("rr_mem_a", mem_a, (i % 2 == 0) ? 4'h3 : 4'hC);
            chk("rr_mem_di", mem_di, (i % 2 == 0) ? 8'h30 : 8'hC1);
        end
        ld_valid = '0;
        tick();
        chk("rr_total", ld_wr_total, CNT_EN ? 32'd4 : 32'd0);

        // CPU beats a pending loader
        cpu_cs = 1'b1; cpu_we = 1'b1; cpu_ad = 4'h4; cpu_d = 8'hAA;
        ld_addr[3:0] = 4'h7; ld_data[7:0] = 8'h5A; ld_valid = 2'b01;
        #1;
        chk("cpu_blocks_ready", ld_ready, 2'b00);
        tick();
        chk("cpu_ce", mem_ce, 1'b1);
        chk("cpu_we", mem_we, 1'b1);
        chk("cpu_a", mem_a, 4'h4);
        chk("cpu_di", mem_di, 8'hAA);
        cpu_cs = 1'b0;
        #1;
        chk("ld_after_cpu", ld_ready, 2'b01);
        tick();
        ld_valid = '0;
        chk("ld_after_cpu_a", mem_a, 4'h7);
        chk("ld_after_cpu_di", mem_di, 8'h5A);

        // Clear request wins over CPU and loader
        clr_start = 1'b1; cpu_cs = 1'b1; ld_valid = 2'b10;
        #1;
        chk("clr_blocks_ready", ld_ready, 2'b00);
        tick();
        clr_start = 1'b0; cpu_cs = 1'b0; ld_valid = 2'b11;
        chk("clr_no_issue", mem_ce, 1'b0);
        chk("clr_busy_set", clr_busy, 1'b1);
        tick();
        chk("clr_first_ce", mem_ce, 1'b1);
        chk("clr_first_a", mem_a, 4'h0);
        found = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (clr_done) begin
                found = 1;
                break;
            end
            chk("fill_ready_low", ld_ready, 2'b00);
            tick();
        end
        chk("clr_done_seen", found, 1);
        chk("clr_total_cleared", ld_wr_total, 32'd0);
        ld_valid = '0;
        tick();

        // Reset in the middle of a sweep
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        found = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (mem_ce && mem_a == 4'h6) begin
                found = 1;
                break;
            end
        end
        chk("mid_fill_reached", found, 1);
        reset_n = 1'b0;
        ld_valid = 2'b01;
        #1;
        chk("rst_ready", ld_ready, 2'b00);
        tick();
        ld_valid = '0;
        chk("rst_ce", mem_ce, 1'b0);
        chk("rst_we", mem_we, 1'b0);
        chk("rst_a", mem_a, 4'h0);
        chk("rst_di", mem_di, 8'h00);
        chk("rst_busy", clr_busy, 1'b0);
        chk("rst_done", clr_done, 1'b0);
        chk("rst_total", ld_wr_total, 32'd0);
        reset_n = 1'b1;
        sweep("resweep");

        // Random traffic obeying the loader handshake
        for (int cyc = 0; cyc < 3000; cyc++) begin
            reset_n   = ($urandom_range(0, 499) != 0);
            clr_start = ($urandom_range(0, 99) == 0);
            cpu_cs    = ($urandom_range(0, 4) == 0);
            cpu_we    = 1'($urandom);
            cpu_ad    = AW'($urandom);
            cpu_d     = DW'($urandom);
            for (int ch = 0; ch < NCH; ch++) begin
                if (!ld_valid[ch] && $urandom_range(0, 2) == 0) begin
                    ld_valid[ch]            = 1'b1;
                    ld_addr[ch*AW +: AW]    = AW'($urandom);
                    ld_data[ch*DW +: DW]    = DW'($urandom);
                end
            end
            @(negedge clk);
            #1;
            acc = ld_valid & ld_ready;
            tick();
            ld_valid = ld_valid & ~acc;
        end
        reset_n = 1'b1; clr_start = 1'b0; cpu_cs = 1'b0; ld_valid = '0;
        repeat (40) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
